// File: rtl/serial_deserializer.sv
// serial_deserializer
//   Collects an LSB-first serial bit stream into DATA_WIDTH-bit words and
//   presents each finished word on a one-entry valid/ready output register.
//   A word that completes while the output register is still held by the
//   consumer is dropped, and the sticky overrun flag records the drop.
//
// Ports
//   clk         in   rising-edge clock
//   resetn      in   asynchronous active-low reset
//   din         in   serial data bit (LSB first)
//   din_valid   in   din is sampled on this edge
//   sync        in   start-of-word marker; restarts word assembly
//   dout        out  assembled word [DATA_WIDTH-1:0]
//   dout_valid  out  dout holds an unconsumed word
//   dout_ready  in   consumer takes dout this cycle
//   overrun     out  sticky: a completed word was dropped
//   ovr_clr     in   synchronous clear of overrun
//   busy        out  a partial word is being assembled
module serial_deserializer #(
   parameter int DATA_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic                  din,
   input  logic                  din_valid,
   input  logic                  sync,
   output logic [DATA_WIDTH-1:0] dout,
   output logic                  dout_valid,
   input  logic                  dout_ready,
   output logic                  overrun,
   input  logic                  ovr_clr,
   output logic                  busy
);

   localparam int              CW       = $clog2(DATA_WIDTH);
   localparam logic [CW-1:0]   LAST_CNT = CW'(DATA_WIDTH - 1);

   // output register states
   localparam logic [0:0] EMPTY = 1'b0;
   localparam logic [0:0] FULL  = 1'b1;

   logic [CW-1:0]         cnt_q,    cnt_d;
   logic [DATA_WIDTH-1:0] sr_q,     sr_d;
   logic [DATA_WIDTH-1:0] dout_q,   dout_d;
   logic [0:0]            ostate_q, ostate_d;
   logic                  ovr_q,    ovr_d;

   logic [DATA_WIDTH-1:0] shifted;
   logic                  word_done;
   logic                  xfer;

   // New bit enters at the MSB; after DATA_WIDTH shifts the first bit sits at [0].
   assign shifted = {din, sr_q[DATA_WIDTH-1:1]};

   // Assembly: count 0 is IDLE, 1..DATA_WIDTH-1 is SHIFT.
   always_comb begin
      cnt_d     = cnt_q;
      sr_d      = sr_q;
      word_done = 1'b0;
      if (sync) begin
         // sync throws away the partial word; a bit sampled with it is bit 0
         if (din_valid) begin
            cnt_d = CW'(1);
            sr_d  = {din, {(DATA_WIDTH-1){1'b0}}};
         end else begin
            cnt_d = '0;
            sr_d  = '0;
         end
      end else if (din_valid) begin
         sr_d = shifted;
         if (cnt_q == LAST_CNT) begin
            cnt_d     = '0;
            word_done = 1'b1;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end
   end

   // Output register: a transfer on the completion edge frees the slot for
   // the new word, so only a completion against a held word is a drop.
   always_comb begin
      xfer     = (ostate_q == FULL) && dout_ready;
      ostate_d = ostate_q;
      dout_d   = dout_q;
      ovr_d    = ovr_q & ~ovr_clr;
      if (word_done) begin
         if ((ostate_q == EMPTY) || xfer) begin
            dout_d   = shifted;
            ostate_d = FULL;
         end else begin
            ovr_d = 1'b1;   // a drop wins over a simultaneous clear
         end
      end else if (xfer) begin
         ostate_d = EMPTY;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cnt_q    <= '0;
         sr_q     <= '0;
         dout_q   <= '0;
         ostate_q <= EMPTY;
         ovr_q    <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         sr_q     <= sr_d;
         dout_q   <= dout_d;
         ostate_q <= ostate_d;
         ovr_q    <= ovr_d;
      end
   end

   assign dout       = dout_q;
   assign dout_valid = (ostate_q == FULL);
   assign overrun    = ovr_q;
   assign busy       = (cnt_q != '0);

endmodule
